// File: rtl/fifo_buffer.sv
// fifo_buffer: single-clock elastic buffer, DEPTH words of WIDTH bits, reads return strict write order.
// Latency: one cycle; dataOut is registered and valid after the edge that accepts RD, writes readable next edge.
// Backpressure: FULL rejects writes unless paired with a read, EMPTY rejects reads; EN=0 freezes all state.
module fifo_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             RD,
    input  logic             WR,
    input  logic             EN,
    output logic [WIDTH-1:0] dataOut,
    output logic             EMPTY,
    output logic             FULL
);

    // Pointer width follows the depth; DEPTH is expected to be a power of two so pointers wrap naturally.
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);

    // Storage is deliberately not reset: nothing can read a slot before it has been written.
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;

    logic              wr_acc;
    logic              rd_acc;

    // Status flags come straight off the registered occupancy count.
    assign EMPTY = (count == '0);
    assign FULL  = (count == COUNT_FULL);

    // A read only needs a non-empty FIFO. A write on a full FIFO is still taken when a read
    // frees the oldest slot in the same edge; on an empty FIFO the read is refused (no bypass).
    assign rd_acc = EN && RD && !EMPTY;
    assign wr_acc = EN && WR && (!FULL || rd_acc);

    // Storage write port; when full with a paired read, wr_ptr == rd_ptr and the read
    // below still captures the old word because both use the pre-edge contents.
    always_ff @(posedge Clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= dataIn;
        end
    end

    // Pointers, occupancy and registered read data; reset clears everything except storage.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dataOut <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                dataOut <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: directed test-plan steps followed by random traffic, all checked against a queue model.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
// The model keeps the expected contents as a queue and the expected dataOut as a single word.
module tb_fifo_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic             Clk;
    logic             Rst;
    logic [WIDTH-1:0] dataIn;
    logic             RD;
    logic             WR;
    logic             EN;
    logic [WIDTH-1:0] dataOut;
    logic             EMPTY;
    logic             FULL;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents in arrival order plus the last word handed out.
    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] model_out;

    fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .dataIn  (dataIn),
        .RD      (RD),
        .WR      (WR),
        .EN      (EN),
        .dataOut (dataOut),
        .EMPTY   (EMPTY),
        .FULL    (FULL)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic chk_all(input string tag);
        chk({tag, ".dataOut"}, dataOut, model_out);
        chk({tag, ".EMPTY"}, {31'd0, EMPTY}, {31'd0, model_q.size() == 0});
        chk({tag, ".FULL"}, {31'd0, FULL}, {31'd0, model_q.size() == DEPTH});
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance the model, then check.
    task automatic step(input string tag, input logic en, input logic wr, input logic rd,
                        input logic [WIDTH-1:0] din);
        bit was_full;
        bit was_empty;
        @(negedge Clk);
        EN     = en;
        WR     = wr;
        RD     = rd;
        dataIn = din;
        @(posedge Clk);
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        if (en && rd && !was_empty) begin
            model_out = model_q.pop_front();
        end
        if (en && wr && (!was_full || (rd && !was_empty))) begin
            model_q.push_back(din);
        end
        #1;
        chk_all(tag);
    endtask

    // Reset asserted between clock edges; effect must be visible before the next edge.
    task automatic async_reset(input string tag);
        @(negedge Clk);
        #2;
        Rst = 1'b0;
        model_q.delete();
        model_out = '0;
        #1;
        chk({tag, ".EMPTY_now"}, {31'd0, EMPTY}, 32'd1);
        chk({tag, ".dataOut_now"}, dataOut, 32'd0);
        chk({tag, ".FULL_now"}, {31'd0, FULL}, 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        Rst = 1'b0; EN = 1'b0; WR = 1'b0; RD = 1'b0; dataIn = '0;
        model_out = '0;
        #1;
        chk("reset_async.EMPTY", {31'd0, EMPTY}, 32'd1);
        repeat (2) @(posedge Clk);
        #1;
        chk_all("reset");
        chk("reset.dataOut_zero", dataOut, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;

        // Reads on an empty FIFO are ignored.
        for (int i = 0; i < 3; i++) step("rd_empty", 1, 0, 1, 32'hDEAD_0000 + i);
        chk("rd_empty.dataOut_zero", dataOut, 32'd0);

        // Five writes then five reads in order.
        for (int i = 0; i < 5; i++) step("wr5", 1, 1, 0, i);
        for (int i = 0; i < 5; i++) begin
            step("rd5", 1, 0, 1, 32'hFFFF_FFFF);
            chk("rd5.const", dataOut, i);
        end
        chk("rd5.EMPTY_end", {31'd0, EMPTY}, 32'd1);
        step("rd5.hold", 1, 0, 1, '0);
        chk("rd5.hold_const", dataOut, 32'h4);

        // Fill completely, reject an extra write, drain.
        for (int i = 0; i < 8; i++) step("fill8", 1, 1, 0, 32'hA0 + i);
        chk("fill8.FULL", {31'd0, FULL}, 32'd1);
        step("wr_full", 1, 1, 0, 32'hFF);
        for (int i = 0; i < 8; i++) begin
            step("drain8", 1, 0, 1, '0);
            chk("drain8.const", dataOut, 32'hA0 + i);
        end
        chk("drain8.EMPTY", {31'd0, EMPTY}, 32'd1);

        // Steady state at 6 entries with simultaneous read/write across pointer wrap.
        for (int i = 0; i < 6; i++) step("fill6", 1, 1, 0, 32'h100 + i);
        for (int i = 0; i < 10; i++) begin
            step("rw6", 1, 1, 1, 32'h106 + i);
            chk("rw6.const", dataOut, 32'h100 + i);
        end
        for (int i = 0; i < 6; i++) begin
            step("drain6", 1, 0, 1, '0);
            chk("drain6.const", dataOut, 32'h10A + i);
        end

        // Simultaneous read/write when full, then when empty.
        for (int i = 0; i < 8; i++) step("fill_full", 1, 1, 0, 32'h200 + i);
        step("rw_full", 1, 1, 1, 32'h2FF);
        chk("rw_full.oldest", dataOut, 32'h200);
        chk("rw_full.FULL", {31'd0, FULL}, 32'd1);
        for (int i = 0; i < 8; i++) step("drain_full", 1, 0, 1, '0);
        chk("drain_full.last", dataOut, 32'h2FF);
        step("rw_empty", 1, 1, 1, 32'h300);
        chk("rw_empty.hold", dataOut, 32'h2FF);
        chk("rw_empty.EMPTY", {31'd0, EMPTY}, 32'd0);
        step("rw_empty.drain", 1, 0, 1, '0);
        chk("rw_empty.drain_const", dataOut, 32'h300);

        // EN=0 freezes everything.
        step("pre_en", 1, 1, 0, 32'h400);
        for (int i = 0; i < 4; i++) step("en_off", 0, 1, i[0], 32'h500 + i);
        step("en_off.read", 1, 0, 1, '0);
        chk("en_off.const", dataOut, 32'h400);

        // Async reset discards contents.
        step("pre_rst", 1, 1, 0, 32'h600);
        step("pre_rst", 1, 1, 0, 32'h601);
        async_reset("mid_rst");
        step("post_rst", 1, 1, 0, 32'h700);
        step("post_rst", 1, 1, 0, 32'h701);
        step("post_rst.rd", 1, 0, 1, '0);
        chk("post_rst.const0", dataOut, 32'h700);
        step("post_rst.rd", 1, 0, 1, '0);
        chk("post_rst.const1", dataOut, 32'h701);
        step("post_rst.rd", 1, 0, 1, '0);
        chk("post_rst.EMPTY", {31'd0, EMPTY}, 32'd1);

        // Random traffic against the queue model; bias drifts between fill-heavy and drain-heavy.
        for (int i = 0; i < 600; i++) begin
            int wr_bias;
            wr_bias = ((i / 100) % 2 == 0) ? 70 : 30;
            w = $urandom;
            step("rand", ($urandom_range(0, 99) < 90),
                 ($urandom_range(0, 99) < wr_bias),
                 ($urandom_range(0, 99) < (100 - wr_bias)), w);
            if (i == 321) async_reset("rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_buffer.md
Name: fifo_buffer

Overview:
Synchronous single-clock FIFO, 32-bit words, 8 entries by default. Used as a generic elastic buffer between a producer and a consumer in the same clock domain. Reads return data in strict write order. EN is a global enable, and FULL/EMPTY report the FIFO status.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 8, number of storage entries; must be a power of two, at least 2
ADDR_W, 3, pointer width, equal to log2(DEPTH); derived, not overridden independently

Ports:
Clk  input  1  system clock; all state updates on the rising edge
Rst  input  1  asynchronous reset, active-low (0 = reset)
dataIn  input  WIDTH  write data, sampled on the Clk edge when a write is accepted
RD  input  1  read request
WR  input  1  write request
EN  input  1  global enable; when 0, RD and WR are ignored and all state holds
dataOut  output  WIDTH  registered read data
EMPTY  output  1  high when the FIFO holds 0 entries
FULL  output  1  high when the FIFO holds DEPTH entries

Behaviour:
- Interface: one clock (Clk). Reset Rst is asynchronous and active-low.
- Reset (Rst=0, takes effect immediately, independent of Clk):
  - write pointer, read pointer and count cleared to 0
  - dataOut = 0, EMPTY = 1, FULL = 0
  - storage array contents are not cleared, and are unobservable until rewritten
- Internal state: wr_ptr and rd_ptr, each ADDR_W bits, wrapping modulo DEPTH. count is ADDR_W+1 bits, range 0..DEPTH.
- EMPTY = (count==0) and FULL = (count==DEPTH). Both are combinational from the registered count, so they update in the same cycle as the count changes.
- Accepted write: EN=1, WR=1 and FULL=0 at the rising edge.
  - mem[wr_ptr] <= dataIn
  - wr_ptr increments
- Accepted read: EN=1, RD=1 and EMPTY=0 at the rising edge.
  - dataOut <= mem[rd_ptr]
  - rd_ptr increments
  - read latency is one cycle: data is valid on dataOut after the edge that accepts the read
- dataOut holds its last value on any cycle without an accepted read, including EN=0, empty, and after reset (holds 0).
- Write when FULL: ignored. No state change, no error flag, stored data is not corrupted.
- Read when EMPTY: ignored. dataOut and pointers are unchanged.
- Simultaneous RD and WR with EN=1:
  - neither full nor empty: both performed, count unchanged
  - empty: only the write is performed (no write-to-read bypass), count becomes 1, dataOut unchanged
  - full: both performed; the read takes the oldest entry and the write fills the freed slot, count stays DEPTH
- Count update per edge: +1 for write only, -1 for read only, 0 for both or neither.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gap or lost entry. Order is preserved across any number of wraps.
- EN=0: the FIFO is frozen (pointers, count, dataOut held) regardless of RD and WR.
- Reset mid-operation: asserting Rst at any time discards all contents immediately. After Rst is released, the FIFO behaves exactly as after power-up reset.
- No X propagation: dataOut never shows uninitialised memory, because reads are blocked when EMPTY.

Test Plan:
- Reset, then EN=1 with Rst released: EMPTY=1, FULL=0, dataOut=0. RD=1 for 3 cycles leaves dataOut=0 and EMPTY=1.
- Write 0x0,0x1,0x2,0x3,0x4 on consecutive edges, then WR=0, RD=1: dataOut reads 0x0..0x4 in order, one per cycle, each valid after its edge. EMPTY rises after the 5th read, and dataOut then holds 0x4.
- Write 8 words 0xA0..0xA7: FULL=1 after the 8th edge. A 9th write of 0xFF is ignored, and 8 reads return 0xA0..0xA7 followed by EMPTY=1.
- Fill to 6 entries, then RD=WR=1 for 10 cycles with incrementing data: count stays 6, FULL/EMPTY stay 0, and the data order is preserved across pointer wrap.
- When full, RD=WR=1 for one cycle: FULL stays 1 and the oldest word is output. When empty, RD=WR=1 for one cycle: EMPTY goes to 0 and dataOut is unchanged.
- EN=0 with WR=1 and RD=1 toggling for 4 cycles: no state change. Then write 2 words and assert Rst=0 asynchronously between clock edges: EMPTY=1 and dataOut=0 immediately, and later reads return only data written after reset.
